// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared FSM state type and address helper for the refill controller
package cache_refill_ctrl_pkg;

    localparam int ADDR_MAX_BITS = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WB_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        COMMIT  = 3'd5
    } refill_state_e;

    // Line address is {tag, index}; callers zero-extend and truncate to their own widths.
    function automatic logic [ADDR_MAX_BITS-1:0] compose_addr(
        input logic [ADDR_MAX_BITS-1:0] tag,
        input logic [ADDR_MAX_BITS-1:0] index,
        input int unsigned              index_bits
    );
        return (tag << index_bits) | index;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - miss/hit/LRU/tag-array/memory/commit signal bundle
interface cache_refill_ctrl_if #(
    parameter int ASSOCIATIVITY = 2,
    parameter int INDEX_BITS    = 8,
    parameter int OUTPUT_BITS   = 2,
    parameter int TAG_BITS      = 20
);
    localparam int ADDR_BITS = TAG_BITS + INDEX_BITS;

    logic                     miss_valid;
    logic                     miss_ready;
    logic [INDEX_BITS-1:0]    miss_index;
    logic [TAG_BITS-1:0]      miss_tag;

    logic                     hit_valid;
    logic                     hit_ready;
    logic [INDEX_BITS-1:0]    hit_index;
    logic [OUTPUT_BITS-1:0]   hit_way;

    logic [INDEX_BITS-1:0]    line_selector;
    logic [OUTPUT_BITS-1:0]   referenced_set;
    logic                     lru_update;
    logic [OUTPUT_BITS-1:0]   lru_way;

    logic [ASSOCIATIVITY-1:0] way_valid;
    logic [ASSOCIATIVITY-1:0] way_dirty;
    logic [TAG_BITS-1:0]      victim_tag;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [ADDR_BITS-1:0]     wb_addr;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [ADDR_BITS-1:0]     rd_addr;
    logic                     rd_beat;

    logic                     tag_we;
    logic [OUTPUT_BITS-1:0]   tag_way;
    logic [INDEX_BITS-1:0]    tag_index;
    logic [TAG_BITS-1:0]      tag_value;
    logic                     done;
    logic [OUTPUT_BITS-1:0]   done_way;

    modport master (
        input  miss_valid, miss_index, miss_tag,
        output miss_ready,
        input  hit_valid, hit_index, hit_way,
        output hit_ready,
        output line_selector, referenced_set, lru_update,
        input  lru_way,
        input  way_valid, way_dirty, victim_tag,
        output wb_valid, wb_addr,
        input  wb_ready,
        output rd_valid, rd_addr,
        input  rd_ready, rd_beat,
        output tag_we, tag_way, tag_index, tag_value, done, done_way
    );

    modport slave (
        output miss_valid, miss_index, miss_tag,
        input  miss_ready,
        output hit_valid, hit_index, hit_way,
        input  hit_ready,
        input  line_selector, referenced_set, lru_update,
        output lru_way,
        output way_valid, way_dirty, victim_tag,
        input  wb_valid, wb_addr,
        output wb_ready,
        input  rd_valid, rd_addr,
        output rd_ready, rd_beat,
        input  tag_we, tag_way, tag_index, tag_value, done, done_way
    );

endinterface

// File: rtl/cache_refill_ctrl_victim_pick.sv
// rtl/cache_refill_ctrl_victim_pick.sv - victim way: lowest invalid way, else the LRU way
module victim_pick #(
    parameter int ASSOCIATIVITY = 2,
    parameter int OUTPUT_BITS   = 2
) (
    input  logic [ASSOCIATIVITY-1:0] way_valid,
    input  logic [ASSOCIATIVITY-1:0] way_dirty,
    input  logic [OUTPUT_BITS-1:0]   lru_way,
    output logic [OUTPUT_BITS-1:0]   way,
    output logic                     victim_dirty
);

    always_comb begin
        way = lru_way;
        // Scan downwards so the lowest-numbered invalid way is the last to win.
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                way = OUTPUT_BITS'(i);
            end
        end
        victim_dirty = 1'b0;
        for (int i = 0; i < ASSOCIATIVITY; i++) begin
            if (OUTPUT_BITS'(i) == way) begin
                victim_dirty = way_valid[i] && way_dirty[i];
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss refill sequencer: victim pick, writeback, line read, tag commit
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ASSOCIATIVITY = 2,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = 8,
    parameter int OUTPUT_BITS   = 2,
    parameter int TAG_BITS      = 20,
    parameter int LINE_BEATS    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_refill_ctrl_if.master bus
);

    localparam int ADDR_BITS = TAG_BITS + INDEX_BITS;
    localparam int BEAT_BITS = $clog2(LINE_BEATS + 1);

    if (ASSOCIATIVITY < 2 || (ASSOCIATIVITY & (ASSOCIATIVITY - 1)) != 0
        || ENTRIES != (1 << INDEX_BITS) || (1 << OUTPUT_BITS) < ASSOCIATIVITY
        || LINE_BEATS < 1 || ADDR_BITS > ADDR_MAX_BITS) begin : g_bad_params
        $error("cache_refill_ctrl: inconsistent parameters");
    end

    refill_state_e            state, state_next;
    logic [INDEX_BITS-1:0]    idx_q;
    logic [TAG_BITS-1:0]      tag_q;
    logic [OUTPUT_BITS-1:0]   way_q;
    logic [TAG_BITS-1:0]      vtag_q;
    logic [BEAT_BITS-1:0]     beat_q;
    logic [OUTPUT_BITS-1:0]   pick_way;
    logic                     pick_dirty;
    logic                     hit_ok;
    logic                     beat_last;

    victim_pick #(
        .ASSOCIATIVITY (ASSOCIATIVITY),
        .OUTPUT_BITS   (OUTPUT_BITS)
    ) u_victim_pick (
        .way_valid    (bus.way_valid),
        .way_dirty    (bus.way_dirty),
        .lru_way      (bus.lru_way),
        .way          (pick_way),
        .victim_dirty (pick_dirty)
    );

    assign beat_last = (beat_q == BEAT_BITS'(LINE_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            tag_q  <= '0;
            way_q  <= '0;
            vtag_q <= '0;
            beat_q <= '0;
        end else begin
            if (state == IDLE && bus.miss_valid) begin
                idx_q <= bus.miss_index;
                tag_q <= bus.miss_tag;
            end
            // The tag array is addressed by idx_q/pick_way during LOOKUP, so victim_tag is valid only here.
            if (state == LOOKUP) begin
                way_q  <= pick_way;
                vtag_q <= bus.victim_tag;
            end
            if (state == RD_REQ && bus.rd_ready) begin
                beat_q <= '0;
            end else if (state == RD_WAIT && bus.rd_beat) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_next         = state;
        hit_ok             = 1'b1;
        bus.miss_ready     = 1'b0;
        bus.line_selector  = bus.hit_index;
        bus.referenced_set = bus.hit_way;
        bus.lru_update     = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.rd_valid       = 1'b0;
        bus.wb_addr        = ADDR_BITS'(compose_addr(ADDR_MAX_BITS'(vtag_q), ADDR_MAX_BITS'(idx_q), INDEX_BITS));
        bus.rd_addr        = ADDR_BITS'(compose_addr(ADDR_MAX_BITS'(tag_q), ADDR_MAX_BITS'(idx_q), INDEX_BITS));
        bus.tag_we         = 1'b0;
        bus.tag_way        = way_q;
        bus.tag_index      = idx_q;
        bus.tag_value      = tag_q;
        bus.done           = 1'b0;
        bus.done_way       = way_q;

        case (state)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_ok             = 1'b0;
                bus.line_selector  = idx_q;
                bus.referenced_set = pick_way;
                state_next         = pick_dirty ? WB_REQ : RD_REQ;
            end
            WB_REQ: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                bus.rd_valid = 1'b1;
                if (bus.rd_ready) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.rd_beat && beat_last) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                hit_ok             = 1'b0;
                bus.line_selector  = idx_q;
                bus.referenced_set = way_q;
                bus.lru_update     = 1'b1;
                bus.tag_we         = 1'b1;
                bus.done           = 1'b1;
                state_next         = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Hits only reach the LRU when the refill is not using the port this cycle.
        if (bus.hit_valid && hit_ok) begin
            bus.lru_update = 1'b1;
        end
        bus.hit_ready = hit_ok;
    end

endmodule
